decode_pipe_stage: RTL and testbench
====================================

// Module: decode_pipe_stage
// PURPOSE
//   Parametrised, registered decode stage sitting between the fetch and execute stages.
//   - Reads operands and extends immediates.
//   - Resolves the JALR target as an absolute address.
//   - Detects load-use hazards and inserts bubbles.
//   - Presents a valid/ready-registered ID/EX bundle with 1-cycle latency.
//   - Adds write-back bypass, flush, and backpressure, which the plain combinational decode lacks.
// PARAMETERS
//   XLEN      32  datapath / PC width
//   NUM_REGS  32  architectural registers; index 0 hard-wired to zero
//   REG_ID_W  5   register index width, = $clog2(NUM_REGS)
// PORTS
//   clk           in   1         clock, rising edge
//   reset         in   1         asynchronous, active-high reset
//   in_valid      in   1         fetch presents an instruction
//   in_ready      out  1         stage consumes the instruction this cycle
//   instruction   in   32        instruction_type from common package
//   pc_in         in   XLEN      PC of instruction
//   flush         in   1         kill the incoming and the registered instruction (branch redirect)
//   wb_en         in   1         write-back enable
//   wb_id         in   REG_ID_W  write-back destination
//   wb_data       in   XLEN      write-back value
//   out_valid     out  1         ID/EX bundle valid
//   out_ready     in   1         execute accepts the bundle
//   out_pc        out  XLEN      registered pc_in
//   out_rs1_data  out  XLEN      operand 1
//   out_rs2_data  out  XLEN      operand 2
//   out_imm       out  XLEN      extended immediate
//   out_rs1_id    out  REG_ID_W  source ids, for EX forwarding
//   out_rs2_id    out  REG_ID_W  source ids, for EX forwarding
//   out_rd_id     out  REG_ID_W  destination id
//   out_control   out  -         control_type bundle
//   out_jalr      out  1         instruction is JALR (I_TYPE && is_branch)
//   out_jalr_tgt  out  XLEN      (rs1 + imm) & ~1, absolute target
//   hazard_stall  out  1         load-use bubble is being inserted this cycle
// BEHAVIOUR
//   - Reset (async, active-high): all out_* = 0; out_control = all-zero; out_valid = 0; every register-file entry = 0.
//   - Register file:
//       - Write at posedge when wb_en && wb_id != 0; writes to x0 are ignored.
//       - Reads are combinational; x0 always reads 0.
//       - Bypass: if wb_en && wb_id == rsN && rsN != 0, read data = wb_data in the same cycle.
//   - Advance: adv = !out_valid || out_ready.
//   - Hazard: hazard_stall = in_valid && out_valid && out_control.mem_read && out_rd_id != 0
//     && (out_rd_id == rs1 || out_rd_id == rs2). The comparison is conservative: both rs fields are checked for every encoding.
//   - in_ready = adv && !hazard_stall && !flush.
//   - Register update when adv (priority order):
//       - flush: out_valid <= 0 (bubble).
//       - hazard_stall: out_valid <= 0. Instruction is held upstream and reissued next cycle.
//       - else: out_valid <= in_valid, and the payload is captured.
//   - When !adv, all out_* hold (stable under backpressure), except when flush is asserted:
//     flush clears out_valid irrespective of out_ready.
//   - Payload is not updated on bubble cycles; only out_valid is.
//   - Arithmetic: JALR target is an XLEN-bit sum that wraps modulo 2^XLEN; bit 0 is forced to 0.
//   - Immediate extension uses the package function keyed on the control encoding.
//   - Simultaneous wb write and hazard: the bypass still applies when the instruction reissues.
//   - Reset mid-stall or mid-backpressure: out_valid = 0 immediately; no instruction is retained.
// STRUCTURE
//   - common package additions:
//       - decode_out_t struct (pc, rs1/rs2 data, imm, ids, control, jalr, jalr_tgt).
//       - XLEN_DEFAULT constant.
//       - Parametrised immediate_extension.
//   - Sub-module regfile_bypass (NUM_REGS x XLEN):
//       - Async reset, two read ports, one write port.
//       - Write-to-read bypass and x0 masking inside.
//   - Top level holds only hazard logic, JALR adder, control decode instance, and the ID/EX register.
// TESTING
//   1. Reset then in_valid=1, ADDI x1,x0,5 @pc 0x100, out_ready=1 -> next cycle out_valid=1, out_imm=5, out_pc=0x100, out_rd_id=1.
//   2. wb_en=1, wb_id=3, wb_data=0xDEAD in the same cycle as ADD x4,x3,x3 -> out_rs1_data=out_rs2_data=0xDEAD (bypass);
//      wb_id=0 with ADD x5,x0,x0 -> operands 0.
//   3. LW x2 issued, then ADD x6,x2,x1 -> hazard_stall=1 and in_ready=0 for 1 cycle, bubble (out_valid=0),
//      ADD emitted the following cycle.
//   4. out_ready=0 for 3 cycles with a valid bundle -> in_ready=0 and all out_* constant; release -> next instruction captured.
//   5. JALR x1,8(x7) with x7=0x1003 -> out_jalr=1, out_jalr_tgt=0x100A;
//      x7=0xFFFFFFFC, imm=8 -> tgt=0x4 (wrap).
//   6. flush during backpressure with valid payload -> out_valid=0 next cycle, in_ready=0 that cycle;
//      reset asserted mid-stall -> out_valid=0 asynchronously.

Source files
------------

// File: rtl/decode_pipe_stage_pkg.sv
// Shared types and helpers for the decode pipeline stage.
//   instruction_t       : raw 32-bit RV32I instruction word
//   enc_t               : instruction format, selects immediate layout
//   control_t           : decoded control bundle carried into EX
//   decode_out_t        : full ID/EX bundle at default widths
//   control_decode      : opcode -> control_t
//   immediate_extension : format-keyed sign-extended immediate (32-bit)
package decode_pipe_stage_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam int unsigned REG_ID_W_DEFAULT = 5;

  localparam logic [6:0] OpReg    = 7'h33;
  localparam logic [6:0] OpImm    = 7'h13;
  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpJalr   = 7'h67;
  localparam logic [6:0] OpJal    = 7'h6f;
  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpAuipc  = 7'h17;

  typedef logic [31:0] instruction_t;

  typedef enum logic [2:0] {EncR, EncI, EncS, EncB, EncU, EncJ} enc_t;

  typedef struct packed {
    enc_t       enc;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       is_branch;
    logic       alu_src_imm;
    logic [3:0] alu_op;
  } control_t;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0]     pc;
    logic [XLEN_DEFAULT-1:0]     rs1_data;
    logic [XLEN_DEFAULT-1:0]     rs2_data;
    logic [XLEN_DEFAULT-1:0]     imm;
    logic [REG_ID_W_DEFAULT-1:0] rs1_id;
    logic [REG_ID_W_DEFAULT-1:0] rs2_id;
    logic [REG_ID_W_DEFAULT-1:0] rd_id;
    control_t                    control;
    logic                        jalr;
    logic [XLEN_DEFAULT-1:0]     jalr_tgt;
  } decode_out_t;

  // Unknown opcodes decode to an all-zero bundle (no side effects in EX).
  function automatic control_t control_decode(instruction_t instr);
    control_t ctrl;
    ctrl = '0;
    unique case (instr[6:0])
      OpReg: begin
        ctrl.enc       = EncR;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = {instr[30], instr[14:12]};
      end
      OpImm: begin
        ctrl.enc         = EncI;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        // funct7[5] only selects SRAI vs SRLI among the immediate ops.
        ctrl.alu_op      = {(instr[14:12] == 3'b101) & instr[30], instr[14:12]};
      end
      OpLoad: begin
        ctrl.enc         = EncI;
        ctrl.reg_write   = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OpStore: begin
        ctrl.enc         = EncS;
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OpBranch: begin
        ctrl.enc       = EncB;
        ctrl.is_branch = 1'b1;
        ctrl.alu_op    = {1'b0, instr[14:12]};
      end
      OpJalr: begin
        ctrl.enc         = EncI;
        ctrl.reg_write   = 1'b1;
        ctrl.is_branch   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OpJal: begin
        ctrl.enc       = EncJ;
        ctrl.reg_write = 1'b1;
        ctrl.is_branch = 1'b1;
      end
      OpLui, OpAuipc: begin
        ctrl.enc         = EncU;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      default: ctrl = '0;
    endcase
    return ctrl;
  endfunction

  // Returns a 32-bit sign-extended immediate; callers widen with a signed cast to XLEN.
  function automatic logic [31:0] immediate_extension(instruction_t instr, enc_t enc);
    logic [31:0] imm;
    unique case (enc)
      EncI:    imm = {{20{instr[31]}}, instr[31:20]};
      EncS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      EncB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      EncU:    imm = {instr[31:12], 12'b0};
      EncJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_pipe_stage_if.sv
// Fetch-side, write-back and ID/EX-side signals of the decode stage.
//   master : the surrounding pipeline (drives instruction, wb, flush, out_ready)
//   slave  : the decode stage itself
interface decode_pipe_stage_if import decode_pipe_stage_pkg::*; #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_ID_W = 5
);

  logic                in_valid;
  logic                in_ready;
  instruction_t        instruction;
  logic [XLEN-1:0]     pc_in;
  logic                flush;
  logic                wb_en;
  logic [REG_ID_W-1:0] wb_id;
  logic [XLEN-1:0]     wb_data;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [XLEN-1:0]     out_rs1_data;
  logic [XLEN-1:0]     out_rs2_data;
  logic [XLEN-1:0]     out_imm;
  logic [REG_ID_W-1:0] out_rs1_id;
  logic [REG_ID_W-1:0] out_rs2_id;
  logic [REG_ID_W-1:0] out_rd_id;
  control_t            out_control;
  logic                out_jalr;
  logic [XLEN-1:0]     out_jalr_tgt;
  logic                hazard_stall;

  modport master (
    output in_valid, instruction, pc_in, flush, wb_en, wb_id, wb_data, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm, out_rs1_id,
           out_rs2_id, out_rd_id, out_control, out_jalr, out_jalr_tgt, hazard_stall
  );

  modport slave (
    input  in_valid, instruction, pc_in, flush, wb_en, wb_id, wb_data, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm, out_rs1_id,
           out_rs2_id, out_rd_id, out_control, out_jalr, out_jalr_tgt, hazard_stall
  );

endinterface

// File: rtl/decode_pipe_stage_regfile_bypass.sv
// NUM_REGS x XLEN register file, two combinational read ports, one write port.
//   clk, reset        : clock, async active-high reset (clears every entry)
//   wr_en/wr_id/wr_data : write port; writes to x0 are dropped
//   rd_a_id/rd_a_data : read port A (x0 reads 0, same-cycle write is bypassed)
//   rd_b_id/rd_b_data : read port B (same rules)
module decode_pipe_stage_regfile_bypass #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_ID_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [REG_ID_W-1:0] wr_id,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [REG_ID_W-1:0] rd_a_id,
  output logic [XLEN-1:0]     rd_a_data,
  input  logic [REG_ID_W-1:0] rd_b_id,
  output logic [XLEN-1:0]     rd_b_data
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en && wr_id != '0) begin
      regs_q[wr_id] <= wr_data;
    end
  end

  always_comb begin
    rd_a_data = regs_q[rd_a_id];
    if (rd_a_id == '0)                      rd_a_data = '0;
    else if (wr_en && wr_id == rd_a_id)     rd_a_data = wr_data;
  end

  always_comb begin
    rd_b_data = regs_q[rd_b_id];
    if (rd_b_id == '0)                      rd_b_data = '0;
    else if (wr_en && wr_id == rd_b_id)     rd_b_data = wr_data;
  end

endmodule

// File: rtl/decode_pipe_stage.sv
// Registered decode stage between fetch and execute.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of decode_pipe_stage_if (fetch handshake, write-back port,
//                flush, ID/EX bundle with valid/ready, hazard_stall)
// Decodes control, reads/bypasses operands, extends the immediate, computes the JALR
// target and inserts a bubble on a load-use dependency against the bundle held in ID/EX.
module decode_pipe_stage import decode_pipe_stage_pkg::*; #(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_ID_W = $clog2(NUM_REGS)
) (
  input logic               clk,
  input logic               reset,
  decode_pipe_stage_if.slave bus
);

  control_t            ctrl;
  logic [REG_ID_W-1:0] rs1_id, rs2_id, rd_id;
  logic [XLEN-1:0]     rs1_data, rs2_data, imm, jalr_sum;
  logic                adv, hazard;

  logic                valid_q;
  logic [XLEN-1:0]     pc_q, rs1_data_q, rs2_data_q, imm_q, jalr_tgt_q;
  logic [REG_ID_W-1:0] rs1_id_q, rs2_id_q, rd_id_q;
  control_t            control_q;
  logic                jalr_q;

  decode_pipe_stage_regfile_bypass #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .REG_ID_W (REG_ID_W)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (bus.wb_en),
    .wr_id     (bus.wb_id),
    .wr_data   (bus.wb_data),
    .rd_a_id   (rs1_id),
    .rd_a_data (rs1_data),
    .rd_b_id   (rs2_id),
    .rd_b_data (rs2_data)
  );

  always_comb begin
    ctrl     = control_decode(bus.instruction);
    rs1_id   = bus.instruction[15 +: REG_ID_W];
    rs2_id   = bus.instruction[20 +: REG_ID_W];
    // Formats without a destination report rd 0 so EX forwarding never matches them.
    rd_id    = ctrl.reg_write ? bus.instruction[7 +: REG_ID_W] : '0;
    imm      = XLEN'($signed(immediate_extension(bus.instruction, ctrl.enc)));
    jalr_sum = rs1_data + imm;
  end

  // Conservative: both rs fields are compared whatever the incoming format.
  assign hazard = bus.in_valid && valid_q && control_q.mem_read && rd_id_q != '0 &&
                  (rd_id_q == rs1_id || rd_id_q == rs2_id);
  assign adv    = !valid_q || bus.out_ready;

  assign bus.hazard_stall = hazard;
  assign bus.in_ready     = adv && !hazard && !bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_id_q   <= '0;
      rs2_id_q   <= '0;
      rd_id_q    <= '0;
      control_q  <= '0;
      jalr_q     <= 1'b0;
      jalr_tgt_q <= '0;
    end else if (bus.flush) begin
      // Flush wins even under backpressure.
      valid_q <= 1'b0;
    end else if (adv) begin
      if (hazard) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          pc_q       <= bus.pc_in;
          rs1_data_q <= rs1_data;
          rs2_data_q <= rs2_data;
          imm_q      <= imm;
          rs1_id_q   <= rs1_id;
          rs2_id_q   <= rs2_id;
          rd_id_q    <= rd_id;
          control_q  <= ctrl;
          jalr_q     <= (ctrl.enc == EncI) && ctrl.is_branch;
          jalr_tgt_q <= {jalr_sum[XLEN-1:1], 1'b0};
        end
      end
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_rs1_data = rs1_data_q;
  assign bus.out_rs2_data = rs2_data_q;
  assign bus.out_imm      = imm_q;
  assign bus.out_rs1_id   = rs1_id_q;
  assign bus.out_rs2_id   = rs2_id_q;
  assign bus.out_rd_id    = rd_id_q;
  assign bus.out_control  = control_q;
  assign bus.out_jalr     = jalr_q;
  assign bus.out_jalr_tgt = jalr_tgt_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
module tb_decode_pipe_stage;

  localparam logic [31:0] I_ADDI1  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_ADD433 = 32'h00318233; // add  x4,x3,x3
  localparam logic [31:0] I_ADD500 = 32'h000002b3; // add  x5,x0,x0
  localparam logic [31:0] I_LW2    = 32'h00002103; // lw   x2,0(x0)
  localparam logic [31:0] I_ADD621 = 32'h00110333; // add  x6,x2,x1
  localparam logic [31:0] I_ADDIM1 = 32'hfff00513; // addi x10,x0,-1
  localparam logic [31:0] I_LUI    = 32'h123454b7; // lui  x9,0x12345
  localparam logic [31:0] I_JALR   = 32'h008380e7; // jalr x1,8(x7)
  localparam logic [31:0] I_SW     = 32'hfe40ae23; // sw   x4,-4(x1)
  localparam logic [31:0] I_BEQ    = 32'hfe208ce3; // beq  x1,x2,-8
  localparam logic [31:0] I_JAL    = 32'h010000ef; // jal  x1,16
  localparam logic [31:0] I_BAD    = 32'hffffffff; // unknown opcode

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  decode_pipe_stage_if #(.XLEN(32), .REG_ID_W(5)) bus ();

  decode_pipe_stage #(.XLEN(32), .NUM_REGS(32), .REG_ID_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] pc, rs1d, rs2d, imm, tgt;
    logic [4:0]  rs1, rs2, rd;
    logic        jalr, mem_read, mem_write, reg_write, is_branch;
  } exp_t;

  logic [31:0] mrf [32];
  logic        m_valid;
  exp_t        m_out;
  logic        m_hz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (bus.wb_en && bus.wb_id == idx) return bus.wb_data;
    return mrf[idx];
  endfunction

  // Reference decode from the RV32I format tables.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    e = '0;
    e.pc   = pc;
    e.rs1  = ins[19:15];
    e.rs2  = ins[24:20];
    e.rs1d = mread(ins[19:15]);
    e.rs2d = mread(ins[24:20]);
    case (ins[6:0])
      7'h33: e.reg_write = 1;
      7'h13: begin e.reg_write = 1; e.imm = 32'($signed(ins[31:20])); end
      7'h03: begin e.reg_write = 1; e.mem_read = 1; e.imm = 32'($signed(ins[31:20])); end
      7'h23: begin e.mem_write = 1; e.imm = 32'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin
        e.is_branch = 1;
        e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
      end
      7'h67: begin
        e.reg_write = 1; e.is_branch = 1; e.jalr = 1;
        e.imm = 32'($signed(ins[31:20]));
      end
      7'h6f: begin
        e.reg_write = 1; e.is_branch = 1;
        e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
      end
      7'h37, 7'h17: begin e.reg_write = 1; e.imm = {12'h0, ins[31:12]} << 12; end
      default: ;
    endcase
    if (e.reg_write) e.rd = ins[11:7];
    e.tgt = (e.rs1d + e.imm) & 32'hffff_fffe;
    return e;
  endfunction

  always_comb begin
    m_hz = 1'b0;
    if (bus.in_valid && m_valid && m_out.mem_read && m_out.rd != 0 &&
        (m_out.rd == bus.instruction[19:15] || m_out.rd == bus.instruction[24:20]))
      m_hz = 1'b1;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_out   <= '0;
      for (int i = 0; i < 32; i++) mrf[i] <= '0;
    end else begin
      if (bus.wb_en && bus.wb_id != 0) mrf[bus.wb_id] <= bus.wb_data;
      if (bus.flush) m_valid <= 1'b0;
      else if (!m_valid || bus.out_ready) begin
        if (m_hz) m_valid <= 1'b0;
        else begin
          m_valid <= bus.in_valid;
          if (bus.in_valid) m_out <= ref_decode(bus.instruction, bus.pc_in);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cyc_out_valid", bus.out_valid, m_valid);
      chk("cyc_hazard", bus.hazard_stall, m_hz);
      chk("cyc_in_ready", bus.in_ready, (!m_valid || bus.out_ready) && !m_hz && !bus.flush);
      if (m_valid) begin
        chk("cyc_pc", bus.out_pc, m_out.pc);
        chk("cyc_rs1_data", bus.out_rs1_data, m_out.rs1d);
        chk("cyc_rs2_data", bus.out_rs2_data, m_out.rs2d);
        chk("cyc_imm", bus.out_imm, m_out.imm);
        chk("cyc_rs1_id", bus.out_rs1_id, m_out.rs1);
        chk("cyc_rs2_id", bus.out_rs2_id, m_out.rs2);
        chk("cyc_rd_id", bus.out_rd_id, m_out.rd);
        chk("cyc_jalr", bus.out_jalr, m_out.jalr);
        chk("cyc_jalr_tgt", bus.out_jalr_tgt, m_out.tgt);
        chk("cyc_mem_read", bus.out_control.mem_read, m_out.mem_read);
        chk("cyc_mem_write", bus.out_control.mem_write, m_out.mem_write);
        chk("cyc_reg_write", bus.out_control.reg_write, m_out.reg_write);
        chk("cyc_is_branch", bus.out_control.is_branch, m_out.is_branch);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction until accepted (bounded), returns 1 after the accepting edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    logic acc;
    acc = 1'b0;
    bus.in_valid    = 1'b1;
    bus.instruction = ins;
    bus.pc_in       = pc;
    for (int n = 0; n < 16 && !acc; n++) begin
      #1;
      acc = bus.in_ready;
      step();
    end
    chk("issue_accepted", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] id, input logic [31:0] data);
    bus.wb_en   = en;
    bus.wb_id   = id;
    bus.wb_data = data;
  endtask

  initial begin
    bus.in_valid = 0; bus.instruction = 0; bus.pc_in = 0; bus.flush = 0;
    bus.out_ready = 1;
    set_wb(0, 0, 0);
    #22;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_imm", bus.out_imm, 0);
    chk("rst_out_control", 32'(bus.out_control), 0);
    reset = 0;
    step();

    // Basic ADDI.
    issue(I_ADDI1, 32'h100);
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_imm", bus.out_imm, 5);
    chk("addi_pc", bus.out_pc, 32'h100);
    chk("addi_rd", bus.out_rd_id, 1);

    // Same-cycle write-back bypass, and x0 writes ignored.
    set_wb(1, 3, 32'hdead);
    issue(I_ADD433, 32'h104);
    set_wb(0, 0, 0);
    chk("byp_rs1", bus.out_rs1_data, 32'hdead);
    chk("byp_rs2", bus.out_rs2_data, 32'hdead);
    set_wb(1, 0, 32'h1234);
    issue(I_ADD500, 32'h108);
    set_wb(0, 0, 0);
    chk("x0_rs1", bus.out_rs1_data, 0);
    chk("x0_rs2", bus.out_rs2_data, 0);

    // Load-use: one bubble, then reissue picks up both the written and bypassed values.
    issue(I_LW2, 32'h10c);
    bus.in_valid = 1; bus.instruction = I_ADD621; bus.pc_in = 32'h110;
    set_wb(1, 2, 32'h77);
    #1;
    chk("lu_hazard", bus.hazard_stall, 1);
    chk("lu_in_ready", bus.in_ready, 0);
    step();
    chk("lu_bubble", bus.out_valid, 0);
    set_wb(1, 1, 32'h99);
    #1;
    chk("lu_hazard_clear", bus.hazard_stall, 0);
    chk("lu_in_ready_back", bus.in_ready, 1);
    step();
    bus.in_valid = 0;
    set_wb(0, 0, 0);
    chk("lu_valid", bus.out_valid, 1);
    chk("lu_pc", bus.out_pc, 32'h110);
    chk("lu_rs1", bus.out_rs1_data, 32'h77);
    chk("lu_rs2", bus.out_rs2_data, 32'h99);

    // Backpressure holds the bundle.
    issue(I_ADDIM1, 32'h200);
    bus.out_ready = 0;
    bus.in_valid = 1; bus.instruction = I_LUI; bus.pc_in = 32'h204;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_pc_hold", bus.out_pc, 32'h200);
      chk("bp_imm_hold", bus.out_imm, 32'hffffffff);
      step();
    end
    bus.out_ready = 1;
    step();
    bus.in_valid = 0;
    chk("bp_release_pc", bus.out_pc, 32'h204);
    chk("bp_release_imm", bus.out_imm, 32'h12345000);

    // JALR target, including wrap.
    set_wb(1, 7, 32'h1003);
    issue(I_JALR, 32'h300);
    set_wb(0, 0, 0);
    chk("jalr_flag", bus.out_jalr, 1);
    chk("jalr_tgt", bus.out_jalr_tgt, 32'h100a);
    set_wb(1, 7, 32'hfffffffc);
    issue(I_JALR, 32'h304);
    set_wb(0, 0, 0);
    chk("jalr_wrap", bus.out_jalr_tgt, 32'h4);

    // Other formats, checked by the model.
    issue(I_SW, 32'h308);
    chk("sw_imm", bus.out_imm, 32'hfffffffc);
    issue(I_BEQ, 32'h30c);
    chk("beq_imm", bus.out_imm, 32'hfffffff8);
    issue(I_JAL, 32'h310);
    chk("jal_imm", bus.out_imm, 32'h10);
    issue(I_BAD, 32'h314);
    step();

    // Flush under backpressure.
    issue(I_ADD433, 32'h400);
    bus.out_ready = 0; bus.flush = 1;
    bus.in_valid = 1; bus.instruction = I_ADDI1; bus.pc_in = 32'h404;
    #1;
    chk("flush_in_ready", bus.in_ready, 0);
    step();
    chk("flush_valid", bus.out_valid, 0);
    bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
    step();

    // Reset in the middle of a load-use stall.
    issue(I_LW2, 32'h500);
    bus.in_valid = 1; bus.instruction = I_ADD621; bus.pc_in = 32'h504;
    #1;
    chk("rs_hazard", bus.hazard_stall, 1);
    chk("rs_pre_valid", bus.out_valid, 1);
    #2;
    reset = 1;
    #1;
    chk("rs_async_valid", bus.out_valid, 0);
    chk("rs_async_pc", bus.out_pc, 0);
    bus.in_valid = 0;
    @(posedge clk);
    #3;
    reset = 0;
    step();
    issue(I_ADD433, 32'h600);
    chk("rs_rf_cleared", bus.out_rs1_data, 0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
